// File: rtl/matrix_mac_seq.sv
// matrix_mac_seq: sequential lane-wise scale/dot multiply-accumulate over one shared multiplier (option: MM_PIPE_MUL_EN)
module matrix_mac_seq #(
  parameter int LANES = 8,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mm_en,
  input  logic [5:0]         mm_op,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  input  logic [LANES*W-1:0] cin,
  output logic [LANES*W-1:0] co,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int KW = $clog2(LANES + 1);
`ifdef MM_PIPE_MUL_EN
  localparam int LAST = LANES;
`else
  localparam int LAST = LANES - 1;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [LANES*W-1:0] a_r, b_r, res_r, res_n;
  logic [5:0] op_r, sel;
  logic [KW-1:0] k, kk, tgt, add_t;
  logic [W-1:0] prod, add_v;
  logic accept, valid_op, dot, last, add_en, err_r;
  assign accept = mm_en && state != RUN;
  assign valid_op = mm_op != 6'd0 && int'(mm_op) <= LANES + 1;
  assign dot = int'(op_r) == LANES + 1;
  assign last = int'(k) == LAST;
  assign kk = (int'(k) < LANES) ? k : '0;
  assign sel = dot ? 6'(kk) : op_r - 6'd1;
  assign tgt = dot ? '0 : kk;
  assign prod = a_r[sel*W +: W] * b_r[kk*W +: W];
`ifdef MM_PIPE_MUL_EN
  logic [W-1:0] p_r;
  logic [KW-1:0] t_r;
  always_ff @(posedge clk) begin
    p_r <= reset ? '0 : prod;
    t_r <= reset ? '0 : tgt;
  end
  // first RUN cycle only fills the product register
  assign add_v = p_r;
  assign add_t = t_r;
  assign add_en = k != '0;
`else
  assign add_v = prod;
  assign add_t = tgt;
  assign add_en = 1'b1;
`endif
  always_comb begin
    res_n = res_r;
    if (add_en) res_n[add_t*W +: W] = res_r[add_t*W +: W] + add_v;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = accept ? (valid_op ? RUN : DONE) : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
    err = done && err_r;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      res_r <= '0;
      op_r <= '0;
      k <= '0;
      co <= '0;
      err_r <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      res_r <= cin;
      op_r <= mm_op;
      k <= '0;
      err_r <= !valid_op;
      if (!valid_op) co <= cin;
    end else if (state == RUN) begin
      res_r <= res_n;
      k <= k + 1'b1;
      if (last) co <= res_n;
    end
  end
endmodule

// File: tb/tb_matrix_mac_seq.sv
// tb_matrix_mac_seq: randomized and directed checks of matrix_mac_seq against an arithmetic reference model
module tb_matrix_mac_seq;
  localparam int LANES = 8;
  localparam int W = 32;
  localparam int N = LANES * W;
`ifdef MM_PIPE_MUL_EN
  localparam int LAT = LANES + 2;
`else
  localparam int LAT = LANES + 1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mm_en = 1'b0;
  logic [5:0] mm_op = '0;
  logic [N-1:0] a = '0, b = '0, cin = '0;
  logic [N-1:0] co;
  logic busy, done, err;
  int checks = 0;
  int failures = 0;
  matrix_mac_seq #(.LANES(LANES), .W(W)) dut (
    .clk(clk), .reset(reset), .mm_en(mm_en), .mm_op(mm_op),
    .a(a), .b(b), .cin(cin), .co(co), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  function automatic logic [N-1:0] model(input int op, input logic [N-1:0] av, bv, cv);
    logic [N-1:0] r;
    logic [W-1:0] s;
    r = cv;
    if (op >= 1 && op <= LANES) begin
      for (int j = 0; j < LANES; j++) begin
        s = av[(op-1)*W +: W] * bv[j*W +: W];
        r[j*W +: W] = cv[j*W +: W] + s;
      end
    end else if (op == LANES + 1) begin
      s = cv[W-1:0];
      for (int i = 0; i < LANES; i++) s = s + W'(av[i*W +: W] * bv[i*W +: W]);
      r[W-1:0] = s;
    end
    return r;
  endfunction
  function automatic logic [N-1:0] rnd();
    logic [N-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*W +: W] = $urandom;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(input int op, input logic [N-1:0] av, bv, cv);
    mm_op = 6'(op);
    a = av;
    b = bv;
    cin = cv;
    mm_en = 1'b1;
    @(negedge clk);
    mm_en = 1'b0;
  endtask
  task automatic finish_op(input string tag, input logic [N-1:0] exp, input logic exp_err, input int lat, input int start);
    int cyc;
    cyc = start;
    while (!done && cyc < 40) begin
      chk({tag, "_busy_run"}, N'(busy), N'(1));
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, N'(cyc), N'(lat));
    chk({tag, "_busy_done"}, N'(busy), N'(0));
    chk({tag, "_err"}, N'(err), N'(exp_err));
    chk({tag, "_co"}, co, exp);
  endtask
  initial begin
    logic [N-1:0] av, bv, cv, exp_co;
    int op;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_co", co, '0);
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_err", N'(err), N'(0));
    av = '0;
    av[2*W +: W] = 3;
    for (int j = 0; j < LANES; j++) begin
      bv[j*W +: W] = W'(j + 1);
      cv[j*W +: W] = 100;
    end
    issue(3, av, bv, cv);
    finish_op("scale", model(3, av, bv, cv), 1'b0, LAT, 1);
    chk("scale_co0", N'(co[W-1:0]), N'(103));
    chk("scale_co7", N'(co[7*W +: W]), N'(124));
    for (int j = 0; j < LANES; j++) begin
      av[j*W +: W] = W'(j + 1);
      bv[j*W +: W] = 2;
      cv[j*W +: W] = (j == 0) ? 5 : 7;
    end
    issue(9, av, bv, cv);
    chk("b2b_busy", N'(busy), N'(1));
    exp_co = cv;
    exp_co[W-1:0] = 77;
    finish_op("dot", exp_co, 1'b0, LAT, 1);
    av = '0;
    bv = '0;
    cv = '0;
    av[W-1:0] = 32'hFFFF_FFFF;
    bv[W-1:0] = 2;
    cv[W-1:0] = 1;
    @(negedge clk);
    issue(1, av, bv, cv);
    finish_op("wrap", model(1, av, bv, cv), 1'b0, LAT, 1);
    chk("wrap_co0", N'(co[W-1:0]), N'(32'hFFFF_FFFF));
    for (int j = 0; j < LANES; j++) cv[j*W +: W] = W'(j);
    @(negedge clk);
    issue(0, rnd(), rnd(), cv);
    finish_op("inv0", cv, 1'b1, 1, 1);
    @(negedge clk);
    chk("inv0_done_after", N'(done), N'(0));
    chk("inv0_err_after", N'(err), N'(0));
    issue(12, rnd(), rnd(), cv);
    finish_op("inv12", cv, 1'b1, 1, 1);
    for (int t = 0; t < 8; t++) begin
      op = (t < 2) ? LANES + 1 : int'($urandom_range(0, 13));
      av = rnd();
      bv = rnd();
      cv = rnd();
      @(negedge clk);
      issue(op, av, bv, cv);
      finish_op($sformatf("rnd%0d_op%0d", t, op), model(op, av, bv, cv),
                (op == 0 || op > LANES + 1), (op == 0 || op > LANES + 1) ? 1 : LAT, 1);
    end
    av = rnd();
    bv = rnd();
    cv = rnd();
    exp_co = model(4, av, bv, cv);
    @(negedge clk);
    issue(4, av, bv, cv);
    @(negedge clk);
    @(negedge clk);
    mm_en = 1'b1;
    mm_op = 6'd9;
    a = rnd();
    @(negedge clk);
    mm_en = 1'b0;
    a = rnd();
    finish_op("interf", exp_co, 1'b0, LAT, 4);
    @(negedge clk);
    issue(9, rnd(), rnd(), rnd());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_co", co, '0);
    chk("mrst_busy", N'(busy), N'(0));
    chk("mrst_done", N'(done), N'(0));
    chk("mrst_err", N'(err), N'(0));
    for (int i = 0; i < LANES + 3; i++) begin
      @(negedge clk);
      chk("mrst_no_done", N'(done), N'(0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_mac_seq.md
# matrix_mac_seq

Sequential, parametrised successor to the combinational matrix-ops unit. Computes lane-wise scaled-accumulate or dot-product-accumulate over packed vectors using one shared W×W multiplier, iterating one lane per cycle under a start/busy/done handshake. Sits beside the FMM datapath; operands come from the vector register file and `co` writes back.

## Interface
- `LANES`, default 8: lane count; also the number of compute cycles per op.
- `W`, default 32: lane width in bits.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `mm_en` input 1: start strobe; sampled only when the block is not busy.
- `mm_op` input 6: opcode, sampled with `mm_en`.
- `a` input LANES*W: operand A, lane k = `a[k*W +: W]`.
- `b` input LANES*W: operand B, same packing.
- `cin` input LANES*W: accumulator input, same packing.
- `co` output LANES*W: result, held until the next accepted op completes.
- `busy` output 1: op in progress; `mm_en` is ignored while high.
- `done` output 1: one-cycle pulse, `co` valid from this cycle.
- `err` output 1: high with `done` when the op was invalid.

## Operation
- States: IDLE, RUN, DONE. DONE lasts exactly one cycle, then returns to IDLE; DONE accepts `mm_en` exactly like IDLE.
- Accept (IDLE/DONE with `mm_en`=1): latch `a`, `b`, `cin`, `mm_op`; clear lane counter k.
- `mm_op`=1..LANES, scale mode: `co[j] = cin[j] + a[mm_op-1]*b[j]` for every j; lane j computed at count k=j.
- `mm_op`=LANES+1, dot mode: `co[0] = cin[0] + Σk a[k]*b[k]`; `co[j>0] = cin[j]`.
- `mm_op`=0, or >LANES+1: invalid. No RUN; go directly to DONE with `co = cin` (latched) and `err`=1.
- Arithmetic unsigned; each product truncated to W bits, each addition mod 2^W.
- Inputs are not re-sampled after accept; later changes on `a`/`b`/`cin` do not affect the running op.
- `co` changes only on the cycle entering DONE; it does not show partial sums.
- `mm_en` while busy: ignored, not queued.
- `reset` has priority over everything, including mid-RUN: return to IDLE and discard the op without a `done` pulse.

## Timing
- Reset values: `co`=0, `busy`=0, `done`=0, `err`=0, state IDLE, k=0.
- `mm_en`=1 in cycle 0 with a valid op (accepted at end of cycle 0):
  - `busy`=1 in cycles 1..LANES.
  - `done`=1 and `co` valid in cycle LANES+1; `busy`=0 in that cycle.
- With an invalid op, `done`=`err`=1 in cycle 1 and `busy` never rises.
- Back-to-back ops: `mm_en` in the DONE cycle is accepted, so `busy` rises in the next cycle. Throughput is one op per LANES+1 cycles.
- `err` is 0 on every cycle where `done`=0.

## Configuration
- `MM_PIPE_MUL_EN` defined: adds a register stage after the multiplier; RUN lasts LANES+1 cycles.
  - `busy` in cycles 1..LANES+1; `done` in cycle LANES+2.
  - Invalid-op timing is unchanged.
- `MM_PIPE_MUL_EN` undefined: the multiplier feeds the accumulator combinationally; timing as in the Timing section.
- Results are identical in both builds.

## Test plan
All scenarios use LANES=8, W=32.
- Reset held for 2 cycles, then released -> `co`=0, `busy`=0, `done`=0, `err`=0.
- Scale: `mm_op`=3, a lane2=3, `b[j]`=j+1, `cin[j]`=100 -> `co[j]`=100+3(j+1), so `co[0]`=103 and `co[7]`=124; `done` in cycle 9 (cycle 10 with `MM_PIPE_MUL_EN`).
- Dot: `mm_op`=9, `a[k]`=k+1, `b[k]`=2, `cin[0]`=5, `cin[j>0]`=7 -> `co[0]`=77, `co[1..7]`=7, `err`=0.
- Wrap: `mm_op`=1, `a[0]`=0xFFFFFFFF, `b[0]`=2, `cin[0]`=1 -> `co[0]`=0xFFFFFFFF.
- Invalid `mm_op`=0 then `mm_op`=12, each with `cin[j]`=j -> `done`=`err`=1 in cycle 1 each time, `co[j]`=j, `busy` stays 0.
- Interference: during RUN, pulse `mm_en` with a new op and change `a` -> ignored, first result unchanged. Assert `reset` at cycle 4 of a second op -> no `done`, all outputs return to reset values.
